// File: rtl/traffic_pkg.sv
// Shared encodings and default timing for the intersection sequencer.
package traffic_pkg;

   // Light bus encoding; code 3 is never driven.
   typedef enum logic [1:0] {
      RED    = 2'd0,
      YELLOW = 2'd1,
      GREEN  = 2'd2
   } light_t;

   // Scheduler state codes, also exported on the phase debug bus. Code 7 is unused.
   typedef enum logic [2:0] {
      HWY_GREEN    = 3'd0,
      HWY_YELLOW   = 3'd1,
      ALL_RED1     = 3'd2,
      CNTRY_GREEN  = 3'd3,
      CNTRY_YELLOW = 3'd4,
      ALL_RED2     = 3'd5,
      PED_WALK     = 3'd6
   } state_t;

   // Default phase durations in clock cycles.
   localparam int unsigned DEF_HWY_MIN_GREEN   = 8;
   localparam int unsigned DEF_YEL_TIME        = 3;
   localparam int unsigned DEF_ALLRED_TIME     = 2;
   localparam int unsigned DEF_CNTRY_MAX_GREEN = 6;
   localparam int unsigned DEF_WALK_TIME       = 5;
   localparam int unsigned DEF_CNT_W           = 4;

   typedef struct packed {
      light_t hwy;
      light_t cntry;
      logic   walk;
   } lights_t;

   // Light pattern shown in each state; anything unrecognised shows all red.
   function automatic lights_t state_lights(input state_t s);
      lights_t l;
      l.hwy   = RED;
      l.cntry = RED;
      l.walk  = 1'b0;
      case (s)
         HWY_GREEN:    l.hwy   = GREEN;
         HWY_YELLOW:   l.hwy   = YELLOW;
         CNTRY_GREEN:  l.cntry = GREEN;
         CNTRY_YELLOW: l.cntry = YELLOW;
         PED_WALK:     l.walk  = 1'b1;
         default:      ;
      endcase
      return l;
   endfunction

endpackage

// File: rtl/phase_timer.sv
// Per-phase cycle counter: sync clear on phase change, optional saturation at the
// terminal count, and a terminal flag that is true on the last cycle of a D-cycle phase.
module phase_timer #(
   parameter int unsigned CNT_W = 4
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             sclr,
   input  logic             sat_en,
   input  logic [CNT_W-1:0] dur,
   output logic [CNT_W-1:0] count,
   output logic             term
);

   logic [CNT_W-1:0] count_q;

   assign count = count_q;
   assign term  = (count_q == (dur - 1'b1));

   // Count up each cycle; restart on phase change, hold at terminal when saturating.
   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         count_q <= '0;
      end else if (sclr) begin
         count_q <= '0;
      end else if (!(sat_en && term)) begin
         count_q <= count_q + 1'b1;
      end
   end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Intersection sequencer: highway/country lights with programmable phase lengths,
// all-red clearance between conflicting greens and a latched pedestrian walk request.
module traffic_phase_scheduler
   import traffic_pkg::*;
#(
   parameter int unsigned HWY_MIN_GREEN   = DEF_HWY_MIN_GREEN,
   parameter int unsigned YEL_TIME        = DEF_YEL_TIME,
   parameter int unsigned ALLRED_TIME     = DEF_ALLRED_TIME,
   parameter int unsigned CNTRY_MAX_GREEN = DEF_CNTRY_MAX_GREEN,
   parameter int unsigned WALK_TIME       = DEF_WALK_TIME,
   parameter int unsigned CNT_W           = DEF_CNT_W
) (
   input  logic       clk,
   input  logic       clear,
   input  logic       x,
   input  logic       ped_req,
   output logic       ped_ack,
   output logic       walk,
   output logic [1:0] hwy,
   output logic [1:0] cntry,
   output logic [2:0] phase
);

   state_t           state_q;
   state_t           state_d;
   logic             ped_pending;
   logic             ped_ack_q;
   logic             enter_walk;
   logic [CNT_W-1:0] dur;
   logic [CNT_W-1:0] count;
   logic             term;
   logic             sclr;
   logic             sat_en;
   lights_t          lights;

   // Duration of the current phase, fed to the timer's terminal compare.
   always_comb begin
      dur = CNT_W'(1);
      case (state_q)
         HWY_GREEN:    dur = CNT_W'(HWY_MIN_GREEN);
         HWY_YELLOW:   dur = CNT_W'(YEL_TIME);
         ALL_RED1:     dur = CNT_W'(ALLRED_TIME);
         CNTRY_GREEN:  dur = CNT_W'(CNTRY_MAX_GREEN);
         CNTRY_YELLOW: dur = CNT_W'(YEL_TIME);
         ALL_RED2:     dur = CNT_W'(ALLRED_TIME);
         PED_WALK:     dur = CNT_W'(WALK_TIME);
         default:      dur = CNT_W'(1);
      endcase
   end

   // Highway green may last indefinitely, so its timer parks at the minimum.
   assign sat_en = (state_q == HWY_GREEN);
   assign sclr   = (state_d != state_q);

   phase_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk    (clk),
      .clear  (clear),
      .sclr   (sclr),
      .sat_en (sat_en),
      .dur    (dur),
      .count  (count),
      .term   (term)
   );

   // Next-state: country car outranks a waiting pedestrian at the first all-red.
   always_comb begin
      state_d = state_q;
      case (state_q)
         HWY_GREEN: begin
            if (term && (x || ped_pending)) state_d = HWY_YELLOW;
         end
         HWY_YELLOW: begin
            if (term) state_d = ALL_RED1;
         end
         ALL_RED1: begin
            if (term) begin
               if (x)                state_d = CNTRY_GREEN;
               else if (ped_pending) state_d = PED_WALK;
               else                  state_d = HWY_GREEN;
            end
         end
         CNTRY_GREEN: begin
            if (!x || term) state_d = CNTRY_YELLOW;
         end
         CNTRY_YELLOW: begin
            if (term) state_d = ALL_RED2;
         end
         ALL_RED2: begin
            if (term) state_d = ped_pending ? PED_WALK : HWY_GREEN;
         end
         PED_WALK: begin
            if (term) state_d = HWY_GREEN;
         end
         default: state_d = HWY_GREEN;
      endcase
   end

   assign enter_walk = (state_d == PED_WALK) && (state_q != PED_WALK);

   // State register; the unused code falls back to highway green via state_d.
   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         state_q <= HWY_GREEN;
      end else begin
         state_q <= state_d;
      end
   end

   // Pedestrian latch: serving the walk wins over a request arriving on the same edge.
   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         ped_pending <= 1'b0;
         ped_ack_q   <= 1'b0;
      end else begin
         ped_ack_q <= enter_walk;
         if (enter_walk) begin
            ped_pending <= 1'b0;
         end else if (ped_req && (state_q != PED_WALK)) begin
            ped_pending <= 1'b1;
         end
      end
   end

   // Moore decode of the light buses from the registered state.
   always_comb begin
      lights = state_lights(state_q);
      hwy    = lights.hwy;
      cntry  = lights.cntry;
      walk   = lights.walk;
      phase  = state_q;
   end

   assign ped_ack = ped_ack_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Self-checking bench for traffic_phase_scheduler: directed vector tables, a
// mid-phase reset sequence, and randomized traffic against a cycle-count model.
module tb_traffic_phase_scheduler;

   logic       clk = 1'b0;
   logic       clear = 1'b0;
   logic       x = 1'b0;
   logic       ped_req = 1'b0;
   logic       ped_ack;
   logic       walk;
   logic [1:0] hwy;
   logic [1:0] cntry;
   logic [2:0] phase;

   int n_checks = 0;
   int n_errors = 0;

   traffic_phase_scheduler dut (
      .clk     (clk),
      .clear   (clear),
      .x       (x),
      .ped_req (ped_req),
      .ped_ack (ped_ack),
      .walk    (walk),
      .hwy     (hwy),
      .cntry   (cntry),
      .phase   (phase)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit first;  // apply reset before this vector
      int sc;
      bit x;
      bit req;
      int ph;
      bit ack;
   } vec_t;

   vec_t tv[$];

   function automatic void seg(input int sc, input bit first, input bit xv, input bit rq,
                               input int ph, input bit ack, input int n);
      vec_t v;
      for (int k = 0; k < n; k++) begin
         v.first = first && (k == 0);
         v.sc    = sc;
         v.x     = xv;
         v.req   = rq;
         v.ph    = ph;
         v.ack   = ack;
         tv.push_back(v);
      end
   endfunction

   // Light pattern for each phase code as the specification lists it.
   function automatic void exp_lights(input int ph, output int h, output int c, output int w);
      h = 0;
      c = 0;
      w = 0;
      case (ph)
         0: h = 2;
         1: h = 1;
         3: c = 2;
         4: c = 1;
         6: w = 1;
         default: ;
      endcase
   endfunction

   task automatic check_val(input string name, input int sc, input int cyc,
                            input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s sc=%0d cyc=%0d got=%0d expected=%0d", name, sc, cyc, got, exp);
      end
   endtask

   task automatic check_cycle(input int sc, input int cyc, input int ph, input bit ack);
      int  h, c, w;
      bit  inv_ok;
      exp_lights(ph, h, c, w);
      check_val("phase", sc, cyc, 32'(phase), ph);
      check_val("hwy", sc, cyc, 32'(hwy), h);
      check_val("cntry", sc, cyc, 32'(cntry), c);
      check_val("walk", sc, cyc, 32'(walk), w);
      check_val("ped_ack", sc, cyc, 32'(ped_ack), 32'(ack));
      inv_ok = !((hwy != 2'd0 && cntry != 2'd0) ||
                 (walk && (hwy != 2'd0 || cntry != 2'd0)) ||
                 hwy == 2'd3 || cntry == 2'd3);
      check_val("invariant", sc, cyc, 32'(inv_ok), 32'd1);
   endtask

   // Assert clear away from any edge, check the async reset state, release on a negedge.
   task automatic do_reset(input int sc);
      @(negedge clk);
      x       = 1'b0;
      ped_req = 1'b0;
      clear   = 1'b0;
      #1;
      check_cycle(sc, -1, 0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      clear = 1'b1;
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      int dur_of[7];
      int mst, dwell, nxt;
      bit pend, mack, enter, done, xr, rq;

      // Idle: no car, no pedestrian -> highway green forever.
      seg(1, 1'b1, 1'b0, 1'b0, 0, 1'b0, 60);

      // Car waiting from release onward: full cycle with country max-green cutoff.
      seg(2, 1'b1, 1'b1, 1'b0, 0, 1'b0, 8);
      seg(2, 1'b0, 1'b1, 1'b0, 1, 1'b0, 3);
      seg(2, 1'b0, 1'b1, 1'b0, 2, 1'b0, 2);
      seg(2, 1'b0, 1'b1, 1'b0, 3, 1'b0, 6);
      seg(2, 1'b0, 1'b1, 1'b0, 4, 1'b0, 3);
      seg(2, 1'b0, 1'b1, 1'b0, 5, 1'b0, 2);
      seg(2, 1'b0, 1'b1, 1'b0, 0, 1'b0, 8);
      seg(2, 1'b0, 1'b1, 1'b0, 1, 1'b0, 1);

      // Car leaves during yellow: back to highway after all-red, country stays red.
      seg(3, 1'b1, 1'b1, 1'b0, 0, 1'b0, 8);
      seg(3, 1'b0, 1'b1, 1'b0, 1, 1'b0, 2);
      seg(3, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1);
      seg(3, 1'b0, 1'b0, 1'b0, 2, 1'b0, 2);
      seg(3, 1'b0, 1'b0, 1'b0, 0, 1'b0, 6);

      // Pedestrian pulse at cycle 3 with no car.
      seg(4, 1'b1, 1'b0, 1'b0, 0, 1'b0, 3);
      seg(4, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1);
      seg(4, 1'b0, 1'b0, 1'b0, 0, 1'b0, 4);
      seg(4, 1'b0, 1'b0, 1'b0, 1, 1'b0, 3);
      seg(4, 1'b0, 1'b0, 1'b0, 2, 1'b0, 2);
      seg(4, 1'b0, 1'b0, 1'b0, 6, 1'b1, 1);
      seg(4, 1'b0, 1'b0, 1'b1, 6, 1'b0, 4);  // requests during walk are ignored
      seg(4, 1'b0, 1'b0, 1'b0, 0, 1'b0, 12);

      // Car and pedestrian together at cycle 0, car leaves at cycle 15.
      seg(5, 1'b1, 1'b1, 1'b1, 0, 1'b0, 1);
      seg(5, 1'b0, 1'b1, 1'b0, 0, 1'b0, 7);
      seg(5, 1'b0, 1'b1, 1'b0, 1, 1'b0, 3);
      seg(5, 1'b0, 1'b1, 1'b0, 2, 1'b0, 2);
      seg(5, 1'b0, 1'b1, 1'b0, 3, 1'b0, 2);
      seg(5, 1'b0, 1'b0, 1'b0, 3, 1'b0, 1);
      seg(5, 1'b0, 1'b0, 1'b0, 4, 1'b0, 3);
      seg(5, 1'b0, 1'b0, 1'b0, 5, 1'b0, 2);
      seg(5, 1'b0, 1'b0, 1'b0, 6, 1'b1, 1);
      seg(5, 1'b0, 1'b0, 1'b0, 6, 1'b0, 4);
      seg(5, 1'b0, 1'b0, 1'b0, 0, 1'b0, 10);

      cyc = 0;
      for (int i = 0; i < tv.size(); i++) begin
         if (tv[i].first) begin
            do_reset(tv[i].sc);
            cyc = 0;
         end
         x       = tv[i].x;
         ped_req = tv[i].req;
         check_cycle(tv[i].sc, cyc, tv[i].ph, tv[i].ack);
         @(posedge clk);
         #1;
         cyc++;
      end

      // Clear mid-country-green with a pedestrian pending: the request is discarded.
      do_reset(6);
      x       = 1'b1;
      ped_req = 1'b1;
      @(posedge clk);
      #1;
      ped_req = 1'b0;
      repeat (13) @(posedge clk);
      #1;
      check_cycle(6, 14, 3, 1'b0);
      #2;
      clear = 1'b0;
      #1;
      check_cycle(6, 15, 0, 1'b0);
      @(negedge clk);
      clear = 1'b1;
      x     = 1'b0;
      for (int k = 0; k < 40; k++) begin
         check_cycle(6, k, 0, 1'b0);
         @(posedge clk);
         #1;
      end

      // Randomized traffic against a model that counts elapsed cycles per phase.
      dur_of = '{8, 3, 2, 6, 3, 2, 5};
      do_reset(7);
      mst   = 0;
      dwell = 0;
      pend  = 1'b0;
      mack  = 1'b0;
      xr    = 1'b0;
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(0, 9) == 0) xr = ~xr;
         rq      = ($urandom_range(0, 24) == 0);
         x       = xr;
         ped_req = rq;
         check_cycle(7, k, mst, mack);

         done = (dwell >= dur_of[mst] - 1);
         nxt  = mst;
         case (mst)
            0: if (done && (xr || pend)) nxt = 1;
            1: if (done) nxt = 2;
            2: if (done) nxt = xr ? 3 : (pend ? 6 : 0);
            3: if (!xr || done) nxt = 4;
            4: if (done) nxt = 5;
            5: if (done) nxt = pend ? 6 : 0;
            6: if (done) nxt = 0;
            default: nxt = 0;
         endcase
         enter = (nxt == 6) && (mst != 6);
         mack  = enter;
         if (enter) pend = 1'b0;
         else if (rq && mst != 6) pend = 1'b1;
         dwell = (nxt != mst) ? 0 : dwell + 1;
         mst   = nxt;

         @(posedge clk);
         #1;
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
